// File: rtl/riscv_defines.sv
// Shared definitions for the M-extension multiply/divide unit: word width,
// MDU op codes, sequencer states and small op-decoding helpers.
package riscv_defines;

    localparam int WORD_WIDTH    = 32;
    localparam int MDU_DIV_ITERS = WORD_WIDTH;

    // MDU op codes follow the RV32M funct3 encoding
    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    // Divide/remainder ops are exactly those with op[2] set
    localparam logic [2:0] MDU_OP_IS_DIV = 3'b100;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } mdu_state_e;

    function automatic logic mdu_is_div(input logic [2:0] op);
        return |(op & MDU_OP_IS_DIV);
    endfunction

    // Operand a is treated as signed for MUL, MULH, MULHSU, DIV and REM
    function automatic logic mdu_a_signed(input logic [2:0] op);
        return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    // Operand b is treated as signed for MUL, MULH, DIV and REM
    function automatic logic mdu_b_signed(input logic [2:0] op);
        return (op == MDU_MUL) || (op == MDU_MULH) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/riscv_div_step.sv
// One combinational restoring-division step: shift remainder:dividend left
// by one, trial-subtract the divisor and keep the difference when it does
// not borrow. The quotient bit is the inverted borrow.
module riscv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] dividend_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Shift, trial-subtract and restore on borrow
    always_comb begin
        shifted       = {rem, dividend[WIDTH-1]};
        diff          = shifted - {1'b0, divisor};
        q_bit         = ~diff[WIDTH];
        rem_next      = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        dividend_next = {dividend[WIDTH-2:0], 1'b0};
    end

endmodule

// File: rtl/riscv_mdu_seq.sv
// Multiply/divide sequencer. Multiplies take one registered product cycle,
// divides run a WIDTH-step restoring divider followed by a sign-fix cycle,
// and divide-by-zero / signed overflow results are produced at accept time.
// The result is held in DONE until the consumer takes it; kill_i aborts.
module riscv_mdu_seq
    import riscv_defines::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             kill_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    mdu_state_e       state_reg, state_next;
    logic [2:0]       op_reg;
    logic             a_signed_reg, b_signed_reg;
    logic             sign_a_reg, sign_b_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] rem_reg, quot_reg, result_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Request decode at the accept edge
    logic             accept;
    logic             req_is_div, req_a_signed, req_b_signed;
    logic             req_sign_a, req_sign_b;
    logic             div_zero, div_ovf, fast_path;
    logic [WIDTH-1:0] fast_result;

    // Datapath helpers
    logic [WIDTH:0]     mul_a_ext, mul_b_ext;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   step_rem, step_dividend;
    logic               step_q;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    riscv_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem           (rem_reg),
        .dividend      (a_reg),
        .divisor       (b_reg),
        .rem_next      (step_rem),
        .dividend_next (step_dividend),
        .q_bit         (step_q)
    );

    // Decode the incoming request and the fast-path divide results
    always_comb begin
        accept       = req_valid_i & req_ready_o & ~kill_i;
        req_is_div   = mdu_is_div(op_i);
        req_a_signed = mdu_a_signed(op_i);
        req_b_signed = mdu_b_signed(op_i);
        req_sign_a   = req_a_signed & op_a_i[WIDTH-1];
        req_sign_b   = req_b_signed & op_b_i[WIDTH-1];
        div_zero     = (op_b_i == '0);
        div_ovf      = req_a_signed && (op_a_i == MIN_NEG) && (op_b_i == ALL_ONES);
        fast_path    = req_is_div & (div_zero | div_ovf);
        // op[1] distinguishes REM/REMU from DIV/DIVU
        if (div_zero) begin
            fast_result = op_i[1] ? op_a_i : ALL_ONES;
        end else begin
            fast_result = op_i[1] ? '0 : MIN_NEG;
        end
    end

    // Multiply product and divide sign correction
    always_comb begin
        mul_a_ext = {a_signed_reg & a_reg[WIDTH-1], a_reg};
        mul_b_ext = {b_signed_reg & b_reg[WIDTH-1], b_reg};
        prod      = {{(WIDTH-1){mul_a_ext[WIDTH]}}, mul_a_ext}
                  * {{(WIDTH-1){mul_b_ext[WIDTH]}}, mul_b_ext};
        quot_fix  = (sign_a_reg ^ sign_b_reg) ? (~quot_reg + 1'b1) : quot_reg;
        rem_fix   = sign_a_reg ? (~rem_reg + 1'b1) : rem_reg;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; kill always wins
    always_comb begin
        state_next = state_reg;
        if (kill_i) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (!req_is_div) begin
                            state_next = MUL;
                        end else if (fast_path) begin
                            state_next = DONE;
                        end else begin
                            state_next = DIV;
                        end
                    end
                end
                MUL:  state_next = DONE;
                DIV:  if (cnt_reg == '0) state_next = FIX;
                FIX:  state_next = DONE;
                DONE: if (res_ready_i) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Handshake and status outputs
    always_comb begin
        req_ready_o = (state_reg == IDLE);
        busy_o      = (state_reg != IDLE);
        res_valid_o = (state_reg == DONE);
        result_o    = result_reg;
    end

    // Operand capture, divider iteration and result registration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg       <= '0;
            a_signed_reg <= 1'b0;
            b_signed_reg <= 1'b0;
            sign_a_reg   <= 1'b0;
            sign_b_reg   <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            rem_reg      <= '0;
            quot_reg     <= '0;
            cnt_reg      <= '0;
            result_reg   <= '0;
        end else if (accept) begin
            op_reg       <= op_i;
            a_signed_reg <= req_a_signed;
            b_signed_reg <= req_b_signed;
            sign_a_reg   <= req_sign_a;
            sign_b_reg   <= req_sign_b;
            // Divides iterate on magnitudes; multiplies keep raw operands
            a_reg        <= (req_is_div && req_sign_a) ? (~op_a_i + 1'b1) : op_a_i;
            b_reg        <= (req_is_div && req_sign_b) ? (~op_b_i + 1'b1) : op_b_i;
            rem_reg      <= '0;
            quot_reg     <= '0;
            cnt_reg      <= CNT_W'(WIDTH - 1);
            if (fast_path) begin
                result_reg <= fast_result;
            end
        end else if (!kill_i) begin
            case (state_reg)
                MUL: begin
                    result_reg <= (op_reg == MDU_MUL) ? prod[WIDTH-1:0]
                                                      : prod[2*WIDTH-1:WIDTH];
                end
                DIV: begin
                    rem_reg  <= step_rem;
                    a_reg    <= step_dividend;
                    quot_reg <= {quot_reg[WIDTH-2:0], step_q};
                    cnt_reg  <= cnt_reg - 1'b1;
                end
                FIX: begin
                    result_reg <= op_reg[1] ? rem_fix : quot_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mdu_seq.sv
// Self-checking bench for riscv_mdu_seq: directed vectors, randomized ops
// against an arithmetic reference model, back-pressure, kill and async reset.
module tb_riscv_mdu_seq;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        kill = 1'b0;
    logic        res_ready = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        req_ready, res_valid, busy;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    riscv_mdu_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .op_i        (op),
        .op_a_i      (a),
        .op_b_i      (b),
        .kill_i      (kill),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .result_o    (result),
        .busy_o      (busy)
    );

    // Reference result from the RV32M arithmetic rules
    function automatic logic [31:0] model_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] sx, sy, ux, uy, p;
        int si, sj;
        logic ovf;
        sx  = {{32{x[31]}}, x};
        sy  = {{32{y[31]}}, y};
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        si  = x;
        sj  = y;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            OP_MUL:    begin p = sx * sy; return p[31:0];  end
            OP_MULH:   begin p = sx * sy; return p[63:32]; end
            OP_MULHSU: begin p = sx * uy; return p[63:32]; end
            OP_MULHU:  begin p = ux * uy; return p[63:32]; end
            OP_DIV:    return (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(si / sj);
            OP_DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
            OP_REM:    return (y == 0) ? x : ovf ? 32'd0 : 32'(si % sj);
            default:   return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Reference latency, counted from the accept edge
    function automatic int model_latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (!o[2]) return 2;
        if (y == 0) return 1;
        if ((o == OP_DIV || o == OP_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Issue one request, wait (bounded) for the result, then consume it
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output int lat, output bit ready_low);
        @(negedge clk);
        op = o; a = x; b = y; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        ready_low = 1'b1;
        @(negedge clk);
        while (!res_valid && lat < 200) begin
            if (req_ready) ready_low = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (req_ready) ready_low = 1'b0;
        res = result;
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 1'b1 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset: busy=%b res_valid=%b req_ready=%b result=%h required 0 0 1 00000000",
                     busy, res_valid, req_ready, result);
        end
        rst_n = 1'b1;
        $display("reset: busy=%b res_valid=%b req_ready=%b result=%h", busy, res_valid, req_ready, result);
    endtask

    // Directed vector table shared by the mul/div/fast-path tests
    task automatic test_vectors(input string name, input logic [2:0] ops[],
                                input logic [31:0] xs[], input logic [31:0] ys[], input logic [31:0] exps[]);
        logic [31:0] res;
        int lat, exp_lat;
        bit rl;
        for (int i = 0; i < ops.size(); i++) begin
            run_op(ops[i], xs[i], ys[i], res, lat, rl);
            exp_lat = model_latency(ops[i], xs[i], ys[i]);
            $display("%s op=%0d a=%h b=%h result=%h lat=%0d", name, ops[i], xs[i], ys[i], res, lat);
            checks++;
            if (res !== exps[i]) begin
                errors++;
                $display("FAIL %s_result[%0d]: got %h required %h", name, i, res, exps[i]);
            end
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL %s_latency[%0d]: got %0d required %0d", name, i, lat, exp_lat);
            end
            checks++;
            if (!rl) begin
                errors++;
                $display("FAIL %s_ready_low[%0d]: req_ready seen 1 while busy, required 0", name, i);
            end
        end
    endtask

    task automatic test_mul();
        test_vectors("mul",
            '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU},
            '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
            '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
            '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    endtask

    task automatic test_div();
        test_vectors("div",
            '{OP_DIV, OP_REM, OP_DIVU, OP_REMU},
            '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100},
            '{32'd2, 32'd2, 32'd2, 32'd7},
            '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'd2});
    endtask

    task automatic test_fast_path();
        test_vectors("fast",
            '{OP_DIV, OP_REMU, OP_DIV, OP_REM},
            '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000},
            '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
            '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0});
    endtask

    task automatic test_random();
        logic [31:0] x, y, res, exp_res;
        logic [2:0] o;
        int lat, exp_lat, sel;
        bit rl;
        for (int i = 0; i < 40; i++) begin
            o   = 3'($urandom_range(0, 7));
            x   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: y = 32'd0;
                1: y = 32'($urandom_range(1, 15));
                2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                3: y = {{16{x[31]}}, 16'($urandom)};
                default: y = $urandom;
            endcase
            exp_res = model_result(o, x, y);
            exp_lat = model_latency(o, x, y);
            run_op(o, x, y, res, lat, rl);
            $display("rand[%0d] op=%0d a=%h b=%h result=%h lat=%0d", i, o, x, y, res, lat);
            checks++;
            if (res !== exp_res || lat != exp_lat || !rl) begin
                errors++;
                $display("FAIL rand[%0d]: op=%0d a=%h b=%h got %h lat %0d rdylow %0d required %h lat %0d rdylow 1",
                         i, o, x, y, res, lat, rl, exp_res, exp_lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit stable;
        @(negedge clk);
        op = OP_MULHU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 50) begin @(negedge clk); n++; end
        // Hold off the consumer while a new request is already pending
        op = OP_DIVU; a = 32'd100; b = 32'd7; req_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (res_valid !== 1'b1 || result !== 32'hFFFF_FFFE || req_ready !== 1'b0) stable = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL backpressure_hold: res_valid=%b result=%h req_ready=%b required 1 fffffffe 0",
                     res_valid, result, req_ready);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: busy=%b req_ready=%b required 0 1", busy, req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_accept: busy=%b required 1", busy);
        end
        n = 0;
        while (!res_valid && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (res_valid !== 1'b1 || result !== 32'd14) begin
            errors++;
            $display("FAIL backpressure_next: res_valid=%b result=%h required 1 0000000e", res_valid, result);
        end
        $display("back_to_back: held result fffffffe then next result=%h", result);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic test_kill();
        logic [31:0] res;
        int lat;
        bit rl, pulse;
        @(negedge clk);
        op = OP_DIV; a = 32'd1000; b = 32'd3; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        pulse = 1'b0;
        repeat (9) begin
            @(negedge clk);
            if (res_valid) pulse = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (res_valid) pulse = 1'b1;
        end
        checks++;
        if (busy !== 1'b0 || pulse) begin
            errors++;
            $display("FAIL kill_div: busy=%b valid_pulse=%b required 0 0", busy, pulse);
        end
        $display("kill_div: busy=%b valid_pulse=%b", busy, pulse);
        run_op(OP_DIVU, 32'd100, 32'd7, res, lat, rl);
        checks++;
        if (res !== 32'd14 || lat != 34) begin
            errors++;
            $display("FAIL kill_recover: got %h lat %0d required 0000000e lat 34", res, lat);
        end
        $display("kill_recover: DIVU 100/7 result=%h lat=%0d", res, lat);
        @(negedge clk);
        op = OP_MUL; a = 32'd3; b = 32'd4; req_valid = 1'b1; kill = 1'b1;
        @(posedge clk);
        #1 begin req_valid = 1'b0; kill = 1'b0; end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL kill_idle: busy=%b res_valid=%b required 0 0", busy, res_valid);
        end
        $display("kill_idle: busy=%b", busy);
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int lat;
        bit rl;
        @(negedge clk);
        op = OP_DIVU; a = $urandom | 32'h1000_0000; b = 32'd9; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 1'b1 || result !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: busy=%b res_valid=%b req_ready=%b result=%h required 0 0 1 00000000",
                     busy, res_valid, req_ready, result);
        end
        $display("async_reset: busy=%b res_valid=%b req_ready=%b result=%h", busy, res_valid, req_ready, result);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_REMU, 32'd100, 32'd7, res, lat, rl);
        checks++;
        if (res !== 32'd2) begin
            errors++;
            $display("FAIL reset_recover: got %h required 00000002", res);
        end
        $display("reset_recover: REMU 100/7 result=%h", res);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_fast_path();
        test_back_to_back();
        test_kill();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_mdu_seq.md
Name: riscv_mdu_seq

Overview:
- Sequencer for the M-extension multiply/divide unit (MDU) of the RISC-V core. It executes the MDU_* operations.
- Accepts one request at a time from decode/execute over a valid/ready handshake.
- Multiply uses a registered single-cycle product. Divide/remainder uses a 32-iteration restoring divider. Divide-by-zero and signed overflow take a fast path.
- The result is held under a valid/ready handshake until writeback consumes it. A pipeline flush (kill) aborts any in-flight operation.

Parameters:
- WIDTH, 32 (WORD_WIDTH): operand and result width; the divider iteration count equals WIDTH.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  unit can accept a request (state IDLE)
- op_i  in  3  MDU_MUL..MDU_REMU encoding
- op_a_i  in  WIDTH  rs1 operand
- op_b_i  in  WIDTH  rs2 operand
- kill_i  in  1  flush: abort the current operation
- res_valid_o  out  1  result_o valid
- res_ready_i  in  1  consumer accepts result
- result_o  out  WIDTH  operation result
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, result_o=0, res_valid_o=0, busy_o=0, req_ready_o=1.
  - Iteration counter, remainder and quotient registers are cleared.
- States: IDLE, MUL, DIV, FIX, DONE.
- Accept: a request is accepted on a rising edge with req_valid_i & req_ready_o. op, operands and sign flags are captured at that edge.
- IDLE transitions on accept:
  - MUL, MULH, MULHSU, MULHU -> MUL.
  - DIV/REM family with op_b==0 -> DONE. DIV/DIVU result = all ones; REM/REMU result = op_a.
  - DIV/REM with op_a==0x80000000 and op_b==0xFFFFFFFF -> DONE. DIV result = 0x80000000; REM result = 0.
  - Other divides -> DIV. Operands are captured as magnitudes (signed ops) or raw (unsigned); the counter is loaded with WIDTH-1.
- MUL state (1 cycle):
  - Operands are extended to WIDTH+1 bits. MUL/MULH: both signed. MULHSU: a signed, b unsigned. MULHU: both unsigned.
  - The 2*WIDTH product is computed. MUL registers the low WIDTH bits; the others register bits [2W-1:W].
  - Next state: DONE.
- DIV state:
  - One restoring step per cycle: shift remainder:dividend left by 1, trial-subtract the divisor, set the quotient bit if no borrow.
  - The counter decrements; at counter==0 the step completes and the state goes to FIX. DIV therefore lasts exactly WIDTH cycles.
- FIX state (1 cycle):
  - Signed ops: quotient negated if sign_a^sign_b; remainder negated if sign_a.
  - DIV/DIVU select the quotient; REM/REMU select the remainder.
  - Next state: DONE.
- DONE state:
  - res_valid_o=1 and result_o stable.
  - On res_ready_i=1: go to IDLE next cycle. Back-to-back acceptance is not allowed; the earliest new accept is one cycle later.
- Latency from the accept edge to res_valid_o=1:
  - Multiply: 2 cycles.
  - Div-by-zero / overflow: 1 cycle.
  - Normal divide: WIDTH+2 = 34 cycles.
- kill_i:
  - Any state -> IDLE on the next edge; res_valid_o drops that edge.
  - kill_i has priority over acceptance. A req_valid_i in the same cycle as kill_i is not accepted.
  - kill_i in IDLE has no effect beyond dropping the request.
- Reset mid-operation: immediate return to the reset values; no partial result is visible.
- result_o is held after a handshake until the next result loads. Verification checks result_o only while res_valid_o=1.
- Signed/unsigned selection per op:
  - Signed: DIV, REM, MUL, MULH, a-operand of MULHSU.
  - Unsigned: DIVU, REMU, MULHU, b-operand of MULHSU.

Decomposition:
- Package riscv_defines gains:
  - typedef enum mdu_state_e {IDLE, MUL, DIV, FIX, DONE}
  - MDU_DIV_ITERS = WORD_WIDTH
  - MDU_OP_IS_DIV helper constant: op[2] set
  - existing MDU_* op codes are reused
- One sub-module: riscv_div_step. It is a combinational single restoring step with inputs remainder, dividend, divisor and outputs new remainder, new dividend, quotient bit.

Test Plan:
- MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB; res_valid_o exactly 2 cycles after accept; req_ready_o=0 meanwhile.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU 100/7 -> 2. Each has latency 34.
- Fast path, all with latency 1:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
- Back-pressure: hold res_ready_i=0 for 5 cycles after DONE -> result_o and res_valid_o stable, req_ready_o=0. res_ready_i=1 -> IDLE next cycle. A simultaneous req_valid_i is not accepted until IDLE.
- Abort:
  - kill_i on DIV iteration 10 -> IDLE next edge, no res_valid_o pulse. A following DIVU 100/7 -> 14.
  - kill_i with req_valid_i in IDLE -> not accepted.
  - rst_n low mid-divide -> all outputs at reset values immediately.
